// File: rtl/mem_stage_hs.sv
// Single-entry memory stage with valid/ready handshakes on both sides.
// Loads and stores are issued to a simple req/ack memory port with a bounded
// wait; timeouts raise a sticky error. Delayed-branch condition and NZV flag
// outputs travel with the held entry.
module mem_stage_hs #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 9,
    parameter int unsigned CW       = 22,
    parameter int unsigned TW       = 6,
    parameter int unsigned MAX_WAIT = 15   // must be >= 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] control_in,
    input  logic [TW-1:0] inst_type_in,
    input  logic [DW-1:0] result_in,
    input  logic [DW-1:0] data_Rd_in,
    input  logic          hb_Rm_in,
    input  logic          hb_Rn_in,
    input  logic [DW-1:0] delayed_B_in,
    input  logic [2:0]    delayed_cond_in,
    input  logic          N_in,
    input  logic          V_in,
    input  logic          Z_in,
    input  logic          squash_in,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] control_out,
    output logic [TW-1:0] inst_type_out,
    output logic [DW-1:0] result_out,
    output logic          N_out,
    output logic          Z_out,
    output logic          V_out,
    output logic          do_delayed_B,
    output logic [DW-1:0] delayed_B_out,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          mem_err
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [2:0] CondNv = 3'd0;
    localparam logic [2:0] CondAl = 3'd1;
    localparam logic [2:0] CondEq = 3'd2;
    localparam logic [2:0] CondNe = 3'd3;
    localparam logic [2:0] CondLt = 3'd4;
    localparam logic [2:0] CondLe = 3'd5;
    localparam logic [2:0] CondGt = 3'd6;
    localparam logic [2:0] CondGe = 3'd7;

    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    // Value of the wait counter in the last cycle before a timeout.
    localparam logic [WW-1:0] WaitLast = WW'(MAX_WAIT - 1);

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic [CW-1:0] control_q, control_d;
    logic [TW-1:0] inst_q, inst_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] data_rd_q, data_rd_d;
    logic [DW-1:0] dly_b_q, dly_b_d;
    logic [2:0]    cond_q, cond_d;
    // Layout: {hb_Rm, hb_Rn, result}
    logic [DW+1:0] flag_q, flag_d;

    logic accept;
    logic is_mem_in;
    logic cond_true;
    logic lt;
    logic flag_msb;

    assign in_ready  = (state_q == StEmpty) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mem_in = inst_type_in[0] || inst_type_in[1];

    // Next-state: FSM progression, then an accepted entry overrides everything.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        err_d     = err_q;
        control_d = control_q;
        inst_d    = inst_q;
        result_d  = result_q;
        data_rd_d = data_rd_q;
        dly_b_d   = dly_b_q;
        cond_d    = cond_q;
        flag_d    = flag_q;

        case (state_q)
            StEmpty: ;
            StIssue: begin
                if (squash_in) begin
                    state_d = StEmpty;
                end else if (mem_ack) begin
                    state_d = StDone;
                    if (inst_q[0] && !inst_q[1]) begin
                        result_d = mem_rdata;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WaitLast) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (squash_in || out_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (accept) begin
            control_d = control_in;
            inst_d    = inst_type_in;
            result_d  = result_in;
            data_rd_d = data_Rd_in;
            dly_b_d   = delayed_B_in;
            cond_d    = delayed_cond_in;
            wait_d    = '0;
            if (control_in[8]) begin
                flag_d = {hb_Rm_in, hb_Rn_in, result_in};
            end
            // A squash only kills entries headed for the memory port.
            if (is_mem_in) begin
                state_d = squash_in ? StEmpty : StIssue;
            end else begin
                state_d = StDone;
            end
        end
    end

    // State and captured-entry registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StEmpty;
            wait_q    <= '0;
            err_q     <= 1'b0;
            control_q <= '0;
            inst_q    <= '0;
            result_q  <= '0;
            data_rd_q <= '0;
            dly_b_q   <= '0;
            cond_q    <= CondNv;
            flag_q    <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            control_q <= control_d;
            inst_q    <= inst_d;
            result_q  <= result_d;
            data_rd_q <= data_rd_d;
            dly_b_q   <= dly_b_d;
            cond_q    <= cond_d;
            flag_q    <= flag_d;
        end
    end

    // Branch condition from the held code and the forwarded flags.
    always_comb begin
        lt        = N_in ^ V_in;
        cond_true = 1'b0;
        case (cond_q)
            CondNv:  cond_true = 1'b0;
            CondAl:  cond_true = 1'b1;
            CondEq:  cond_true = Z_in;
            CondNe:  cond_true = ~Z_in;
            CondLt:  cond_true = lt;
            CondLe:  cond_true = lt | Z_in;
            CondGt:  cond_true = ~(lt | Z_in);
            CondGe:  cond_true = ~lt;
            default: cond_true = 1'b0;
        endcase
    end

    // Output decode from the held entry.
    always_comb begin
        out_valid     = (state_q == StDone);
        // Squash blanks the request in the same cycle, not only from the next one.
        mem_req       = (state_q == StIssue) && !squash_in;
        mem_we        = mem_req && inst_q[1];
        mem_addr      = result_q[AW-1:0];
        mem_wdata     = data_rd_q;
        mem_err       = err_q;
        control_out   = control_q;
        inst_type_out = inst_q;
        result_out    = result_q;
        do_delayed_B  = out_valid && cond_true;
        delayed_B_out = (inst_q[3] || inst_q[4]) ? data_rd_q : dly_b_q;
        flag_msb      = flag_q[DW-1];
        N_out         = flag_msb;
        Z_out         = (flag_q[DW-1:0] == '0);
        // Overflow patterns over {hb_Rn, hb_Rm, result MSB}: 011 or 100.
        V_out         = (~flag_q[DW] & flag_q[DW+1] & flag_msb) |
                        (flag_q[DW] & ~flag_q[DW+1] & ~flag_msb);
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: handshake latency, memory port behaviour,
// squash, timeout, flags, branch condition and asynchronous reset.
module tb_mem_stage_hs;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 9;
    localparam int unsigned CW = 22;
    localparam int unsigned TW = 6;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] control_in;
    logic [TW-1:0] inst_type_in;
    logic [DW-1:0] result_in;
    logic [DW-1:0] data_Rd_in;
    logic          hb_Rm_in;
    logic          hb_Rn_in;
    logic [DW-1:0] delayed_B_in;
    logic [2:0]    delayed_cond_in;
    logic          N_in, V_in, Z_in;
    logic          squash_in;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] control_out;
    logic [TW-1:0] inst_type_out;
    logic [DW-1:0] result_out;
    logic          N_out, Z_out, V_out;
    logic          do_delayed_B;
    logic [DW-1:0] delayed_B_out;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_err;

    int checks = 0;
    int errors = 0;

    mem_stage_hs #(
        .DW(DW), .AW(AW), .CW(CW), .TW(TW), .MAX_WAIT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .control_in(control_in), .inst_type_in(inst_type_in),
        .result_in(result_in), .data_Rd_in(data_Rd_in),
        .hb_Rm_in(hb_Rm_in), .hb_Rn_in(hb_Rn_in),
        .delayed_B_in(delayed_B_in), .delayed_cond_in(delayed_cond_in),
        .N_in(N_in), .V_in(V_in), .Z_in(Z_in), .squash_in(squash_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .control_out(control_out), .inst_type_out(inst_type_out),
        .result_out(result_out),
        .N_out(N_out), .Z_out(Z_out), .V_out(V_out),
        .do_delayed_B(do_delayed_B), .delayed_B_out(delayed_B_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid        = 1'b0;
        control_in      = '0;
        inst_type_in    = '0;
        result_in       = '0;
        data_Rd_in      = '0;
        hb_Rm_in        = 1'b0;
        hb_Rn_in        = 1'b0;
        delayed_B_in    = '0;
        delayed_cond_in = 3'd0;
        squash_in       = 1'b0;
        mem_ack         = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        logic early_err;

        rst       = 1'b0;
        out_ready = 1'b1;
        N_in      = 1'b0;
        V_in      = 1'b0;
        Z_in      = 1'b0;
        mem_rdata = '0;
        idle_inputs();

        // Reset values while reset is held
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_result", result_out, 0);
        chk("rst_control", control_out, 0);
        chk("rst_inst", inst_type_out, 0);
        chk("rst_do_b", do_delayed_B, 0);
        chk("rst_N", N_out, 0);
        chk("rst_Z", Z_out, 1);
        chk("rst_V", V_out, 0);

        #9 rst = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();

        // ADD, result 0, flag load: 1-cycle latency, Z=1, no memory access
        in_valid     = 1'b1;
        inst_type_in = 6'h00;
        result_in    = 16'h0000;
        control_in   = 22'h000105;
        #1;
        chk("add_in_ready", in_ready, 1);
        chk("add_req_accept", mem_req, 0);
        tick();
        idle_inputs();
        #1;
        chk("add_out_valid", out_valid, 1);
        chk("add_control", control_out, 22'h000105);
        chk("add_Z", Z_out, 1);
        chk("add_N", N_out, 0);
        chk("add_req", mem_req, 0);
        tick();
        chk("add_retired", out_valid, 0);

        // STR with ack in the third ISSUE cycle
        in_valid     = 1'b1;
        inst_type_in = 6'h02;
        result_in    = 16'h01A5;
        data_Rd_in   = 16'hBEEF;
        tick();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            mem_ack = (c == 3);
            #1;
            chk("str_req", mem_req, 1);
            chk("str_we", mem_we, 1);
            chk("str_addr", mem_addr, 9'h1A5);
            chk("str_wdata", mem_wdata, 16'hBEEF);
            chk("str_not_valid", out_valid, 0);
            tick();
        end
        mem_ack   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("str_out_valid_c4", out_valid, 1);
        chk("str_req_done", mem_req, 0);
        chk("str_result", result_out, 16'h01A5);
        chk("str_Z_kept", Z_out, 1);
        tick();
        chk("str_hold", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("str_retired", out_valid, 0);

        // LDR with immediate ack, then back-to-back BX and EQ entries
        in_valid     = 1'b1;
        inst_type_in = 6'h01;
        result_in    = 16'h0033;
        mem_rdata    = 16'h1234;
        mem_ack      = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("ldr_req", mem_req, 1);
        chk("ldr_we", mem_we, 0);
        chk("ldr_addr", mem_addr, 9'h033);
        chk("ldr_not_valid", out_valid, 0);
        tick();
        mem_ack         = 1'b0;
        in_valid        = 1'b1;
        inst_type_in    = 6'h08;
        result_in       = 16'h4321;
        data_Rd_in      = 16'h0ABC;
        delayed_B_in    = 16'h0DEF;
        delayed_cond_in = 3'd1;
        #1;
        chk("ldr_out_valid", out_valid, 1);
        chk("ldr_result", result_out, 16'h1234);
        chk("b2b_in_ready", in_ready, 1);
        tick();
        inst_type_in    = 6'h00;
        result_in       = 16'h0005;
        delayed_cond_in = 3'd2;
        #1;
        chk("bx_out_valid", out_valid, 1);
        chk("bx_inst", inst_type_out, 6'h08);
        chk("bx_result", result_out, 16'h4321);
        chk("bx_target", delayed_B_out, 16'h0ABC);
        chk("bx_al_taken", do_delayed_B, 1);
        tick();
        idle_inputs();
        out_ready = 1'b0;
        Z_in      = 1'b0;
        #1;
        chk("eq_out_valid", out_valid, 1);
        chk("eq_target", delayed_B_out, 16'h0DEF);
        chk("eq_z0", do_delayed_B, 0);
        Z_in = 1'b1;
        #1;
        chk("eq_z1", do_delayed_B, 1);
        out_ready = 1'b1;
        tick();
        Z_in = 1'b0;
        chk("eq_retired", out_valid, 0);

        // Flags: hb_Rn=0 hb_Rm=1 result=0x8000, cond LT
        in_valid        = 1'b1;
        control_in      = 22'h000100;
        hb_Rn_in        = 1'b0;
        hb_Rm_in        = 1'b1;
        result_in       = 16'h8000;
        delayed_cond_in = 3'd4;
        N_in            = 1'b1;
        V_in            = 1'b1;
        out_ready       = 1'b0;
        tick();
        idle_inputs();
        #1;
        chk("flg_V", V_out, 1);
        chk("flg_N", N_out, 1);
        chk("flg_Z", Z_out, 0);
        chk("lt_nv_equal", do_delayed_B, 0);
        N_in = 1'b0;
        #1;
        chk("lt_nv_differ", do_delayed_B, 1);
        out_ready = 1'b1;
        tick();
        chk("lt_gated", do_delayed_B, 0);
        N_in = 1'b0;
        V_in = 1'b0;

        // STR accepted with squash: never writes, back to EMPTY
        in_valid     = 1'b1;
        inst_type_in = 6'h02;
        result_in    = 16'h0010;
        squash_in    = 1'b1;
        #1;
        chk("sq_acc_we", mem_we, 0);
        tick();
        idle_inputs();
        #1;
        chk("sq_acc_req", mem_req, 0);
        chk("sq_acc_we2", mem_we, 0);
        chk("sq_acc_valid", out_valid, 0);
        chk("sq_acc_empty", in_ready, 1);

        // Squash while in ISSUE blanks the request in that cycle
        in_valid     = 1'b1;
        inst_type_in = 6'h02;
        tick();
        idle_inputs();
        #1;
        chk("sq_iss_req_pre", mem_req, 1);
        squash_in = 1'b1;
        #1;
        chk("sq_iss_req", mem_req, 0);
        chk("sq_iss_we", mem_we, 0);
        tick();
        squash_in = 1'b0;
        #1;
        chk("sq_iss_valid", out_valid, 0);
        chk("sq_iss_empty", in_ready, 1);

        // Squash in DONE drops the entry
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        idle_inputs();
        #1;
        chk("sq_done_pre", out_valid, 1);
        squash_in = 1'b1;
        #1;
        chk("sq_done_same", out_valid, 1);
        tick();
        squash_in = 1'b0;
        #1;
        chk("sq_done_valid", out_valid, 0);
        chk("sq_done_empty", in_ready, 1);
        out_ready = 1'b1;

        // Timeout: no ack for 15 cycles
        in_valid     = 1'b1;
        inst_type_in = 6'h01;
        result_in    = 16'h0077;
        mem_rdata    = 16'hFFFF;
        tick();
        idle_inputs();
        out_ready  = 1'b0;
        req_cycles = 0;
        early_err  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (out_valid) break;
            if (mem_req) req_cycles++;
            if (mem_err) early_err = 1'b1;
            tick();
        end
        chk("to_req_cycles", req_cycles, 15);
        chk("to_early_err", early_err, 0);
        chk("to_err", mem_err, 1);
        chk("to_done", out_valid, 1);
        chk("to_result", result_out, 16'h0077);
        out_ready = 1'b1;
        tick();
        tick();
        chk("to_err_sticky", mem_err, 1);

        // Reset during ISSUE drops the request immediately
        in_valid     = 1'b1;
        inst_type_in = 6'h02;
        result_in    = 16'h0042;
        tick();
        idle_inputs();
        #1;
        chk("rst_iss_req_pre", mem_req, 1);
        rst = 1'b0;
        #1;
        chk("rst_iss_req", mem_req, 0);
        chk("rst_iss_we", mem_we, 0);
        chk("rst_iss_err", mem_err, 0);
        chk("rst_iss_result", result_out, 0);
        #1 rst = 1'b1;
        tick();
        chk("rst_iss_ready", in_ready, 1);
        chk("rst_iss_valid", out_valid, 0);
        chk("rst_iss_req2", mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameters SHALL be: DW, default 16, datapath width; AW, default 9, memory address width (AW<=DW); CW, default 22, control bus width; TW, default 6, instruction-type width; MAX_WAIT, default 15, maximum memory wait cycles.
REQ-002 Ports SHALL be:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- in_valid / in_ready, in / out, 1 each, upstream handshake.
- control_in, in, CW, control word; bit 8 = flag load.
- inst_type_in, in, TW, instruction type; bit1 = STR, bit0 = LDR, bit3/bit4 = BX/BLX.
- result_in, in, DW, ALU result / address.
- data_Rd_in, in, DW, store data / BX target.
- hb_Rm_in / hb_Rn_in, in, 1 each, operand MSBs for overflow.
- delayed_B_in, in, DW, branch target.
- delayed_cond_in, in, 3, condition: NV=0 AL=1 EQ=2 NE=3 LT=4 LE=5 GT=6 GE=7.
- N_in, V_in, Z_in, in, 1 each, forwarded flags for condition evaluation.
- squash_in, in, 1, later-stage branch taken; kills current entry.
- out_valid / out_ready, out / in, 1 each, downstream handshake.
- control_out, out, CW; inst_type_out, out, TW; result_out, out, DW.
- N_out, Z_out, V_out, out, 1 each, registered flags.
- do_delayed_B, out, 1; delayed_B_out, out, DW.
- mem_req, mem_we, out, 1 each; mem_addr, out, AW; mem_wdata, out, DW; mem_rdata, in, DW; mem_ack, in, 1.
- mem_err, out, 1, sticky memory-timeout flag.

Function
REQ-003 The block SHALL hold one entry and use FSM states EMPTY, ISSUE, DONE.
REQ-004 in_ready SHALL be 1 in EMPTY, and 1 in DONE when out_ready=1; otherwise 0.
REQ-005 On accept (in_valid and in_ready), all *_in fields SHALL be captured in one cycle.
- Next state is ISSUE if inst_type_in bit0 or bit1 is set; otherwise DONE.
REQ-006 In ISSUE:
- mem_req=1; mem_we = captured STR bit.
- mem_addr = result[AW-1:0]; mem_wdata = captured data_Rd.
- Each cycle without mem_ack SHALL increment a wait counter.
REQ-007 On mem_ack in ISSUE:
- For LDR, result_out SHALL take mem_rdata.
- State SHALL go to DONE on the next edge.
- Accept-to-out_valid latency SHALL be 1 cycle for non-memory ops and 1+k cycles for memory ops, where k is the number of cycles until mem_ack.
REQ-008 If the wait counter reaches MAX_WAIT without mem_ack:
- mem_err SHALL set; it clears only on reset.
- State SHALL go to DONE; result_out is unchanged.
REQ-009 If squash_in=1 in the cycle an entry would enter ISSUE, or while in ISSUE:
- mem_req and mem_we SHALL be 0 in that cycle.
- State SHALL go to EMPTY; no store is performed.
REQ-010 squash_in in DONE SHALL drop the entry to EMPTY with out_valid=0 from the next cycle.
REQ-011 out_valid SHALL be 1 only in DONE.
- out_valid=1 with out_ready=1 retires the entry.
- A simultaneous accept SHALL load the new entry in the same edge (back-to-back throughput 1/cycle).
REQ-012 do_delayed_B SHALL be combinational from the captured condition and N_in/V_in/Z_in:
- NV=0; AL=1; EQ=Z; NE=~Z; LT=N!=V; LE=LT|Z; GT=~LE; GE=N==V.
- It is gated to 0 unless out_valid=1.
REQ-013 delayed_B_out SHALL equal captured data_Rd when inst_type bit3 or bit4 is set, else captured delayed_B_in.
REQ-014 The flag register SHALL load {hb_Rm_in, hb_Rn_in, result_in} on accept only when control_in[8]=1.
- N_out = flag result MSB.
- Z_out = (flag result == 0).
- V_out = 1 iff {hb_Rn, hb_Rm, result MSB} is 3'b011 or 3'b100.
REQ-015 All widths SHALL follow the parameters; no output is hard-coded to 16 bits.

Reset
REQ-016 On rst=0, regardless of clk:
- State = EMPTY; wait counter = 0; mem_err = 0.
- out_valid, mem_req, mem_we, do_delayed_B = 0.
- control_out, inst_type_out, result_out = 0.
- Flag register and captured condition = 0 (NV).
REQ-017 Reset asserted during ISSUE SHALL drop mem_req in the same cycle; the pending access SHALL be abandoned.
REQ-018 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-019 ADD, result_in=0x0000, control_in[8]=1 -> out_valid after 1 cycle, Z_out=1, N_out=0, mem_req never asserted.
REQ-020 STR, result_in=0x01A5, data_Rd_in=0xBEEF, mem_ack after 3 cycles -> mem_req/mem_we held for 3 cycles, mem_addr=0x1A5, mem_wdata=0xBEEF, out_valid on cycle 4.
REQ-021 LDR, mem_rdata=0x1234 with immediate ack -> result_out=0x1234, out_valid 2 cycles after accept.
REQ-022 STR accepted with squash_in=1 -> mem_we never 1, state returns to EMPTY, out_valid=0.
REQ-023 Flags hb_Rn=0, hb_Rm=1, result=0x8000, cond LT -> V_out=1, N_out=1, do_delayed_B=0 (N_out=1 == V_out=1).
REQ-024 Memory op with no ack for MAX_WAIT=15 cycles -> mem_err=1 on cycle 15, then DONE; rst=0 mid-ISSUE -> mem_req=0 immediately.
